// File: rtl/perf_monitor_pkg.sv
// Shared definitions for the performance monitor: FSM encoding, CPU event
// channel indices and the "counting this edge" rule.
package perf_pkg;

    typedef enum logic [1:0] {
        PM_IDLE   = 2'd0,
        PM_RUN    = 2'd1,
        PM_FROZEN = 2'd2,
        PM_DONE   = 2'd3
    } pm_state_e;

    localparam int EV_STALL   = 0;
    localparam int EV_FLUSH   = 1;
    localparam int EV_RETIRE  = 2;
    localparam int EV_LOADUSE = 3;

    // Leaving FROZEN resumes counting on the same edge, so FROZEN counts too.
    function automatic logic is_counting(input pm_state_e st, input logic freeze);
        return ((st == PM_RUN) || (st == PM_FROZEN)) && !freeze;
    endfunction

endpackage

// File: rtl/perf_monitor_sat_counter.sv
// Saturating up-counter with clear and a sticky overflow flag.
// An increment attempted at all-ones holds the value and raises ovf.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         ovf
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Count register and sticky saturation flag; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            if (count == {W{1'b1}}) begin
                ovf <= 1'b1;
            end else begin
                count <= count + ONE;
            end
        end
    end

endmodule

// File: rtl/perf_monitor.sv
// Performance monitor: cycle and per-channel event counters under an
// IDLE/RUN/FROZEN/DONE controller, with a snapshot bank and registered read port.
module perf_monitor
    import perf_pkg::*;
#(
    parameter  int NUM_EVENTS = 4,
    parameter  int CNT_WIDTH  = 32,
    parameter  int MAX_CYCLES = 64,
    localparam int SEL_W      = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  freeze_i,
    input  logic                  clear_i,
    input  logic                  snap_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic [SEL_W-1:0]      rd_sel_i,
    output logic [CNT_WIDTH-1:0]  rd_data_o,
    output logic [CNT_WIDTH-1:0]  cycle_o,
    output logic [NUM_EVENTS:0]   ovf_o,
    output logic                  snap_valid_o,
    output logic                  done_o,
    output logic [1:0]            state_o
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0]     LAST_SEL = SEL_W'(NUM_EVENTS);

    pm_state_e              state_r;
    pm_state_e              state_next_s;
    logic                   count_en_s;
    logic                   budget_hit_s;
    logic [NUM_EVENTS:0]    inc_s;
    logic [NUM_EVENTS:0]    ovf_s;
    logic [CNT_WIDTH-1:0]   live_s   [NUM_EVENTS+1];
    logic [CNT_WIDTH-1:0]   shadow_r [NUM_EVENTS+1];
    logic [CNT_WIDTH-1:0]   rd_data_r;
    logic                   snap_valid_r;
    logic                   done_r;

    // Index 0 is the cycle counter, index k is event channel k-1.
    for (genvar k = 0; k <= NUM_EVENTS; k++) begin : g_cnt
        sat_counter #(.W(CNT_WIDTH)) u_cnt (
            .clk   (clk_i),
            .rst   (rst_i),
            .clr   (clear_i),
            .inc   (inc_s[k]),
            .count (live_s[k]),
            .ovf   (ovf_s[k])
        );
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= PM_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; only clear leaves DONE, start/freeze are ignored there.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            PM_IDLE: begin
                if (start_i) state_next_s = PM_RUN;
                else         state_next_s = PM_IDLE;
            end
            PM_RUN, PM_FROZEN: begin
                if (freeze_i)          state_next_s = PM_FROZEN;
                else if (budget_hit_s) state_next_s = PM_DONE;
                else                   state_next_s = PM_RUN;
            end
            PM_DONE: begin
                if (clear_i) state_next_s = PM_IDLE;
                else         state_next_s = PM_DONE;
            end
            default: state_next_s = PM_IDLE;
        endcase
    end

    // Counter enables and budget detection; a cleared edge never reaches the budget.
    always_comb begin
        count_en_s   = is_counting(state_r, freeze_i);
        budget_hit_s = 1'b0;
        if ((MAX_CYCLES != 0) && count_en_s && !clear_i && (live_s[0] != {CNT_WIDTH{1'b1}})) begin
            budget_hit_s = ((live_s[0] + CNT_ONE) == MAX_CNT);
        end else begin
            budget_hit_s = 1'b0;
        end
        inc_s[0] = count_en_s;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            inc_s[k+1] = count_en_s & event_i[k];
        end
    end

    // done tracks the state being entered so it lines up with state_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (state_next_s == PM_DONE);
        end
    end

    // Shadow bank and read port; a same-edge read sees the pre-snapshot value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k <= NUM_EVENTS; k++) begin
                shadow_r[k] <= '0;
            end
            rd_data_r    <= '0;
            snap_valid_r <= 1'b0;
        end else begin
            snap_valid_r <= snap_i;
            if (snap_i) begin
                for (int k = 0; k <= NUM_EVENTS; k++) begin
                    shadow_r[k] <= live_s[k];
                end
            end
            rd_data_r <= (rd_sel_i <= LAST_SEL) ? shadow_r[rd_sel_i] : '0;
        end
    end

    assign rd_data_o    = rd_data_r;
    assign cycle_o      = live_s[0];
    assign ovf_o        = ovf_s;
    assign snap_valid_o = snap_valid_r;
    assign done_o       = done_r;
    assign state_o      = state_r;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a behavioural model checks the default
// instance every cycle; an 8-bit unlimited instance is checked for saturation.
module tb_perf_monitor;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0, freeze_i = 1'b0, clear_i = 1'b0, snap_i = 1'b0;
    logic [3:0]  event_i = 4'd0;
    logic [2:0]  rd_sel_i = 3'd0;
    logic [31:0] rd_data_o, cycle_o;
    logic [4:0]  ovf_o;
    logic        snap_valid_o, done_o;
    logic [1:0]  state_o;

    logic        b_start = 1'b0, b_clear = 1'b0, b_snap = 1'b0;
    logic [3:0]  b_ev = 4'd0;
    logic [2:0]  b_sel = 3'd0;
    logic [7:0]  b_rd, b_cycle;
    logic [4:0]  b_ovf;
    logic        b_snapv, b_done;
    logic [1:0]  b_state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    perf_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(32), .MAX_CYCLES(64)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .freeze_i(freeze_i),
        .clear_i(clear_i), .snap_i(snap_i), .event_i(event_i), .rd_sel_i(rd_sel_i),
        .rd_data_o(rd_data_o), .cycle_o(cycle_o), .ovf_o(ovf_o),
        .snap_valid_o(snap_valid_o), .done_o(done_o), .state_o(state_o)
    );

    perf_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(8), .MAX_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .start_i(b_start), .freeze_i(1'b0),
        .clear_i(b_clear), .snap_i(b_snap), .event_i(b_ev), .rd_sel_i(b_sel),
        .rd_data_o(b_rd), .cycle_o(b_cycle), .ovf_o(b_ovf),
        .snap_valid_o(b_snapv), .done_o(b_done), .state_o(b_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: 0=IDLE 1=RUN 2=FROZEN 3=DONE, cnt[0]=cycles, cnt[k]=channel k-1
    localparam longint unsigned MAXV = 64'hFFFF_FFFF;
    int              m_state = 0;
    longint unsigned m_cnt[5];
    longint unsigned m_shadow[5];
    logic [4:0]      m_ovf = 5'd0;
    longint unsigned m_rd = 0;
    bit              m_snapv = 1'b0, m_done = 1'b0, chk_en = 1'b0;

    task automatic model_step();
        bit counting;
        longint unsigned prev_cycles;
        counting    = ((m_state == 1) || (m_state == 2)) && !freeze_i;
        prev_cycles = m_cnt[0];
        if (rst_i) begin
            for (int k = 0; k < 5; k++) begin
                m_cnt[k] = 0;
                m_shadow[k] = 0;
            end
            m_state = 0; m_ovf = 5'd0; m_rd = 0; m_snapv = 1'b0;
            chk_en = 1'b1;
        end else begin
            m_rd    = (rd_sel_i <= 3'd4) ? m_shadow[rd_sel_i] : 0;
            m_snapv = snap_i;
            if (snap_i) for (int k = 0; k < 5; k++) m_shadow[k] = m_cnt[k];
            if (clear_i) begin
                for (int k = 0; k < 5; k++) m_cnt[k] = 0;
                m_ovf = 5'd0;
            end else if (counting) begin
                for (int k = 0; k < 5; k++) begin
                    if (k == 0 || event_i[k-1]) begin
                        if (m_cnt[k] == MAXV) m_ovf[k] = 1'b1;
                        else m_cnt[k] = m_cnt[k] + 1;
                    end
                end
            end
            if (m_state == 3) begin
                if (clear_i) m_state = 0;
            end else if (m_state == 0) begin
                if (start_i) m_state = 1;
            end else if (freeze_i) begin
                m_state = 2;
            end else if (!clear_i && prev_cycles + 1 == 64) begin
                m_state = 3;
            end else begin
                m_state = 1;
            end
        end
        m_done = (m_state == 3);
    endtask

    // Compare on the falling edge, then advance the model with the inputs the next rising edge samples.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("state", state_o, m_state);
                chk("cycle", cycle_o, m_cnt[0]);
                chk("ovf", ovf_o, m_ovf);
                chk("snap_valid", snap_valid_o, m_snapv);
                chk("done", done_o, m_done);
                chk("rd_data", rd_data_o, m_rd);
            end
            model_step();
        end
    end

    longint unsigned exp1[5] = '{64, 64, 64, 0, 0};

    initial begin
        ticks(2);
        rst_i = 1'b0;
        chk("rst_state", state_o, 0);
        chk("rst_cycle", cycle_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ovf", ovf_o, 0);

        // Budget run: 64 counted edges, then DONE holds
        event_i = 4'b0011; start_i = 1'b1;
        ticks(1);
        start_i = 1'b0;
        chk("start_no_count", cycle_o, 0);
        ticks(64);
        chk("budget_done", done_o, 1);
        chk("budget_cycle", cycle_o, 64);
        chk("budget_state", state_o, 3);
        start_i = 1'b1; freeze_i = 1'b1;
        ticks(3);
        start_i = 1'b0; freeze_i = 1'b0;
        ticks(2);
        chk("done_hold_cycle", cycle_o, 64);
        snap_i = 1'b1;
        ticks(1);
        snap_i = 1'b0;
        chk("model_pin_ch1", m_shadow[2], 64);
        chk("model_pin_ch2", m_shadow[3], 0);
        for (int k = 0; k < 5; k++) begin
            rd_sel_i = 3'(k);
            ticks(1);
            chk("budget_read", rd_data_o, exp1[k]);
        end
        rd_sel_i = 3'd5;
        ticks(1);
        chk("read_out_of_range", rd_data_o, 0);
        start_i = 1'b1;
        ticks(1);
        start_i = 1'b0;
        chk("start_ignored_in_done", state_o, 3);
        clear_i = 1'b1;
        ticks(1);
        clear_i = 1'b0;
        chk("clear_to_idle", state_o, 0);
        chk("clear_cycle", cycle_o, 0);
        rd_sel_i = 3'd2;
        ticks(1);
        chk("shadow_survives_clear", rd_data_o, 64);

        // Freeze: 10 run, 5 frozen, 3 resumed
        event_i = 4'b0101; start_i = 1'b1;
        ticks(1);
        start_i = 1'b0;
        ticks(10);
        chk("pre_freeze_cycle", cycle_o, 10);
        freeze_i = 1'b1;
        ticks(5);
        chk("frozen_state", state_o, 2);
        chk("frozen_cycle", cycle_o, 10);
        freeze_i = 1'b0;
        ticks(3);
        chk("resume_cycle", cycle_o, 13);
        chk("resume_state", state_o, 1);
        snap_i = 1'b1;
        ticks(1);
        snap_i = 1'b0;
        rd_sel_i = 3'd1; ticks(1); chk("freeze_ch0", rd_data_o, 13);
        rd_sel_i = 3'd3; ticks(1); chk("freeze_ch2", rd_data_o, 13);
        rd_sel_i = 3'd2; ticks(1); chk("freeze_ch1", rd_data_o, 0);
        rd_sel_i = 3'd7; ticks(1); chk("read_sel7", rd_data_o, 0);

        // Snapshot together with clear at cycle 20
        rst_i = 1'b1;
        ticks(1);
        rst_i = 1'b0;
        event_i = 4'b1111; start_i = 1'b1;
        ticks(1);
        start_i = 1'b0;
        ticks(20);
        chk("cycle20", cycle_o, 20);
        snap_i = 1'b1; clear_i = 1'b1;
        ticks(1);
        snap_i = 1'b0; clear_i = 1'b0;
        chk("snap_clear_valid", snap_valid_o, 1);
        chk("snap_clear_cycle", cycle_o, 0);
        rd_sel_i = 3'd0;
        ticks(1);
        chk("snap_clear_read", rd_data_o, 20);
        chk("snap_valid_pulse_end", snap_valid_o, 0);
        chk("cycle_restart", cycle_o, 1);

        // Reset mid-run at cycle 30 with a snapshot pending
        ticks(10);
        snap_i = 1'b1;
        ticks(1);
        snap_i = 1'b0;
        ticks(18);
        chk("cycle30", cycle_o, 30);
        rst_i = 1'b1; snap_i = 1'b1;
        ticks(1);
        rst_i = 1'b0; snap_i = 1'b0;
        chk("midrst_cycle", cycle_o, 0);
        chk("midrst_state", state_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_snap_valid", snap_valid_o, 0);
        for (int k = 0; k < 5; k++) begin
            rd_sel_i = 3'(k);
            ticks(1);
            chk("midrst_shadow", rd_data_o, 0);
        end
        event_i = 4'd0;

        // 8-bit unlimited instance: saturation and sticky flags
        b_start = 1'b1;
        ticks(1);
        b_start = 1'b0; b_ev = 4'b0100;
        ticks(300);
        b_snap = 1'b1;
        ticks(1);
        b_snap = 1'b0;
        b_sel = 3'd3; ticks(1); chk("sat_ch2", b_rd, 255);
        b_sel = 3'd0; ticks(1); chk("sat_cycle_shadow", b_rd, 255);
        chk("sat_ovf", b_ovf, 5'b01001);
        chk("sat_cycle_live", b_cycle, 255);
        ticks(5);
        chk("sat_ovf_sticky", b_ovf, 5'b01001);
        chk("unlimited_state", b_state, 1);
        chk("unlimited_done", b_done, 0);
        b_clear = 1'b1;
        ticks(1);
        b_clear = 1'b0;
        chk("sat_ovf_cleared", b_ovf, 0);
        chk("sat_cycle_cleared", b_cycle, 0);

        ticks(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
